// File: rtl/dlx_dmem_if.sv
// CPU-side request/response bundle of the DLX data-memory controller.
// Handshake: the CPU raises cpu_req with stable fields and holds them until cpu_ack; rdata/err are valid only with cpu_ack.
`timescale 1ns/1ps
interface dlx_dmem_if #(
  parameter int CPU_ADDR_SIZE = 32,
  parameter int WORD_SIZE     = 32
);
  logic                     cpu_req;
  logic                     cpu_we;
  logic [1:0]               cpu_size;
  logic                     cpu_unsigned;
  logic [CPU_ADDR_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0]     cpu_wdata;
  logic [WORD_SIZE-1:0]     cpu_rdata;
  logic                     cpu_ack;
  logic                     cpu_err;
  logic                     cpu_stall;

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err, cpu_stall
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err, cpu_stall
  );
endinterface

// File: rtl/dlx_dmem_ctrl.sv
// DLX MEM-stage data-memory controller: byte/half/word loads and stores onto a word-addressed,
// DATA_READY-handshaked memory with a shared data bus; sub-word stores are read-modify-write.
`timescale 1ns/1ps
module dlx_dmem_ctrl #(
  parameter int ADDRESS_SIZE  = 16,
  parameter int WORD_SIZE     = 32,
  parameter int CPU_ADDR_SIZE = 32,
  parameter int TIMEOUT       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  dlx_dmem_if.slave               cpu,
  output logic [ADDRESS_SIZE-1:0] ADDRESS,
  output logic                    ENABLE,
  output logic                    READNOTWRITE,
  input  logic                    DATA_READY,
  inout  wire  [WORD_SIZE-1:0]    INOUT_DATA,
  output logic [2:0]              dbg_state
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           wait_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [1:0]              off_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic                    rmw_q;
  logic [15:0]             wdata_q;
  logic [WORD_SIZE-1:0]    wr_word_q;
  logic [WORD_SIZE-1:0]    rdata_q;
  logic                    misaligned;
  logic                    accept;
  logic                    timeout_hit;
  logic                    unused_addr_bits;

  // Address bits above the memory word address wrap silently.
  assign unused_addr_bits = ^cpu.cpu_addr[CPU_ADDR_SIZE-1:ADDRESS_SIZE+2];

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [15:0] d,
                                              input logic half, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    if (half) begin
      if (off[1]) r[15:0] = d;
      else        r[31:16] = d;
    end else begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end
    return r;
  endfunction

  always_comb begin
    case (cpu.cpu_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = cpu.cpu_addr[0];
      2'b10:   misaligned = (cpu.cpu_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // A DATA_READY seen in the first ENABLE cycle may be left over from the previous access.
  assign accept      = DATA_READY && (wait_q != '0);
  assign timeout_hit = (wait_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu.cpu_req) begin
          if (misaligned)                  state_d = S_ERR;
          else if (!cpu.cpu_we)            state_d = S_RD;
          else if (cpu.cpu_size == 2'b10)  state_d = S_WR;
          else                             state_d = S_RD;
        end
      end
      S_RD: begin
        if (accept)           state_d = rmw_q ? S_WR : S_DONE;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_WR: begin
        if (accept)           state_d = S_DONE;
        else if (timeout_hit) state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      addr_q    <= '0;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      rmw_q     <= 1'b0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_RD || state_q == S_WR) && state_d == state_q) wait_q <= wait_q + CW'(1);
      else                                                           wait_q <= '0;
      if (state_q == S_IDLE && cpu.cpu_req) begin
        addr_q    <= cpu.cpu_addr[ADDRESS_SIZE+1:2];
        off_q     <= cpu.cpu_addr[1:0];
        size_q    <= cpu.cpu_size;
        uns_q     <= cpu.cpu_unsigned;
        rmw_q     <= cpu.cpu_we && (cpu.cpu_size != 2'b10);
        wdata_q   <= cpu.cpu_wdata[15:0];
        wr_word_q <= cpu.cpu_wdata;
      end
      if (state_q == S_RD && accept) begin
        if (rmw_q) wr_word_q <= merge_store(INOUT_DATA, wdata_q, size_q[0], off_q);
        else       rdata_q   <= fmt_load(INOUT_DATA, size_q, off_q, uns_q);
      end
      if (state_d == S_ERR) rdata_q <= '0;
    end
  end

  assign ADDRESS        = addr_q;
  assign ENABLE         = (state_q == S_RD) || (state_q == S_WR);
  assign READNOTWRITE   = (state_q != S_WR);
  assign INOUT_DATA     = (state_q == S_WR) ? wr_word_q : {WORD_SIZE{1'bz}};
  assign cpu.cpu_ack    = (state_q == S_DONE) || (state_q == S_ERR);
  assign cpu.cpu_err    = (state_q == S_ERR);
  assign cpu.cpu_stall  = ENABLE || (state_q == S_IDLE && cpu.cpu_req);
  assign cpu.cpu_rdata  = rdata_q;
  assign dbg_state      = state_q;
endmodule

// File: doc/dlx_dmem_ctrl.md
Name: dlx_dmem_ctrl

Overview:
Data-memory access controller between the DLX MEM stage and the word-addressed, handshaked read/write data memory.
- Turns CPU byte-addressed loads and stores (byte/half/word, signed/unsigned) into single-word memory transactions.
- Sub-word stores use read-modify-write.
- Stalls the pipeline until the memory raises DATA_READY, and reports misalignment and timeout errors.

Parameters:
ADDRESS_SIZE, 16, memory word-address width
WORD_SIZE, 32, data width; only 32 supported (4 byte lanes)
CPU_ADDR_SIZE, 32, CPU byte-address width
TIMEOUT, 16, max cycles waiting for DATA_READY per memory access

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active low
cpu_req  in  1  access request; held until cpu_ack
cpu_we  in  1  1=store, 0=load
cpu_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned)
cpu_unsigned  in  1  load zero-extend when 1, sign-extend when 0
cpu_addr  in  CPU_ADDR_SIZE  byte address
cpu_wdata  in  WORD_SIZE  store data, right-justified
cpu_rdata  out  WORD_SIZE  formatted load data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  error flag, valid with cpu_ack
cpu_stall  out  1  pipeline hold
ADDRESS  out  ADDRESS_SIZE  memory word address = cpu_addr[ADDRESS_SIZE+1:2]
ENABLE  out  1  memory access enable
READNOTWRITE  out  1  1=read, 0=write
DATA_READY  in  1  memory completion
INOUT_DATA  inout  WORD_SIZE  bidirectional data bus

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE.
  - ENABLE=0, READNOTWRITE=1, ADDRESS=0, INOUT_DATA=Z.
  - cpu_ack=0, cpu_err=0, cpu_stall=0, cpu_rdata=0, timeout counter=0.
  - Reset mid-transaction aborts the transaction with no ack.
- States: IDLE, RD, WR, DONE, ERR.
- Request latching:
  - In IDLE with cpu_req=1, latch addr, we, size, unsigned and wdata; ignore cpu_req in every other state.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=11) goes to ERR with no memory access.
  - Otherwise: load goes to RD; word store goes to WR; byte/half store goes to RD with an internal rmw flag set.
- RD: ENABLE=1, READNOTWRITE=1, ADDRESS held stable.
  - DATA_READY is accepted only when wait_cnt>=1 (at least one full cycle of ENABLE); memory DATA_READY may be stale-high.
  - On accept, capture INOUT_DATA.
  - If rmw: merge the store lanes into the captured word, then go to WR.
  - Else: format the load, then go to DONE.
- WR: ENABLE=1, READNOTWRITE=0, INOUT_DATA driven with the write word.
  - Same DATA_READY acceptance rule as RD; on accept go to DONE.
- Bus drive: INOUT_DATA is driven only in WR; Z in all other states, including the RD→WR turnaround cycle boundary.
- wait_cnt:
  - Clears on entry to RD/WR and increments each cycle there.
  - Reaching TIMEOUT without an accepted DATA_READY goes to ERR.
- DONE: ENABLE=0; cpu_ack=1 for 1 cycle; cpu_err=0; back to IDLE.
- ERR: ENABLE=0; cpu_ack=1 and cpu_err=1 for 1 cycle; cpu_rdata=0; back to IDLE. A partially done RMW never writes.
- Byte lanes (big-endian): offset 0 = bits[31:24], offset 3 = bits[7:0]. Half offset 0 = [31:16], offset 2 = [15:0].
- Loads: the selected lane is right-justified, then sign- or zero-extended per cpu_unsigned. Word loads pass through.
- Stores: cpu_wdata[7:0] (byte) or [15:0] (half) is placed in the addressed lane; other lanes come from the read word.
- cpu_stall = (state!=IDLE && state!=DONE && state!=ERR) || (state==IDLE && cpu_req).
- cpu_rdata holds its value until the next ack.
- Address upper bits above ADDRESS_SIZE+1 are ignored (wrap).
- Latency with DATA_READY arriving at wait_cnt=1:
  - word load/store: ack 3 cycles after req sampled;
  - sub-word store: 5 cycles.

Test Plan:
- Word store to addr 0x0000_0010 with wdata 0xDEADBEEF, memory responding: expect a write at ADDRESS=4 with INOUT_DATA=0xDEADBEEF. Then word load from the same address: cpu_rdata=0xDEADBEEF, ack on cycle 3, err=0.
- Memory word 0x80FF7F01 at ADDRESS=2, load byte from addr 0x8 signed: cpu_rdata=0xFFFFFF80. Load byte from addr 0xB unsigned: 0x00000001. Load half from addr 0xA signed: 0x00007F01.
- Memory word 0x11223344, byte store of 0xAB to offset 1: read then write of 0x11AB3344. Bus must be Z during RD; ack at cycle 5.
- Half load from addr 0x3: cpu_ack=1 and cpu_err=1 next cycle, ENABLE never asserted, memory contents unchanged.
- DATA_READY held 0: ENABLE high for TIMEOUT=16 cycles, then ack+err, ENABLE=0. A stale DATA_READY=1 in the first ENABLE cycle must be ignored.
- rst asserted during WR: ENABLE=0 and INOUT_DATA=Z immediately (async). No ack; the next request proceeds normally.
